// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared instruction/data memory between the CPU datapath and the loader port.
// Each access is a fixed-latency transaction: grant, MEM_LAT held memory cycles, then a one-cycle ready.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2,
  parameter int CPU_PRI = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic [DW-1:0] ldr_rdata,
  output logic          ldr_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    grant
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       last_owner;  // 1 = loader owned the previous access
  logic       own_ldr;
  logic       lat_we;
  logic       start;
  logic       pick_ldr;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    // Loader wins if alone, or under round-robin when the CPU had the last turn.
    pick_ldr  = ldr_req && (!cpu_req || ((CPU_PRI == 0) && !last_owner));
    case (state)
      IDLE: begin
        if (cpu_req || ldr_req) begin
          start     = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: if (cnt == 4'd0) state_nxt = RESP;
      RESP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Enables decode straight from state so an asynchronous reset drops them at once.
  assign mem_en = (state == ACCESS);
  assign mem_we = (state == ACCESS) && (cnt == 4'd0) && lat_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last_owner <= 1'b1;
      own_ldr    <= 1'b0;
      lat_we     <= 1'b0;
      grant      <= 2'b00;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      ldr_rdata  <= '0;
      cpu_ready  <= 1'b0;
      ldr_ready  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            own_ldr   <= pick_ldr;
            grant     <= pick_ldr ? 2'b10 : 2'b01;
            mem_addr  <= pick_ldr ? ldr_addr  : cpu_addr;
            mem_wdata <= pick_ldr ? ldr_wdata : cpu_wdata;
            lat_we    <= pick_ldr ? ldr_we    : cpu_we;
            cnt       <= CNT_INIT;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            if (!lat_we) begin
              if (own_ldr) ldr_rdata <= mem_rdata;
              else         cpu_rdata <= mem_rdata;
            end
            cpu_ready <= !own_ldr;
            ldr_ready <= own_ldr;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          cpu_ready  <= 1'b0;
          ldr_ready  <= 1'b0;
          last_owner <= own_ldr;
          grant      <= 2'b00;
        end
        default: ;
      endcase
    end
  end

endmodule
